// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and datapath select encodings for the
// multicycle MIPS control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ORIEX,
        S_IWB,
        S_BRANCH,
        S_JUMP
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory request; expired flags the cycle in
// which the count has reached WAIT_MAX.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = $clog2(WAIT_MAX + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WAIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs per state, with mem_ready
// gating in the memory states and a wait-state timeout to FETCH.
//
// state  | meaning              state  | meaning
// FETCH  | read instr, PC+4     EXEC   | R-type ALU op
// DECODE | reg read, br target  ALUWB  | write rd
// MEMADR | compute address      ADDIEX | A + sext(imm)
// MEMRD  | data read            ORIEX  | A | zext(imm)
// MEMWB  | load writeback       IWB    | write rt
// MEMWR  | data write           BRANCH | compare, cond PC write
//                               JUMP   | PC <= jump target
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_MAX      = 15,
    parameter int WAIT_W        = $clog2(WAIT_MAX + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       ne,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immsel,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       memwrite,
    output logic       half,
    output logic       b,
    output logic       illegal,
    output logic       buserr
);

    state_e state_q, state_d;
    logic   ready_eff;
    logic   in_mem;
    logic   expired;
    logic   timeout;
    logic   wait_inc;

    assign ready_eff = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign in_mem    = is_mem_state(state_q);
    assign timeout   = in_mem && !ready_eff && expired;
    // Counting only while stalled; any state change, ready or timeout restarts it.
    assign wait_inc  = in_mem && !ready_eff && !expired;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!wait_inc),
        .inc     (wait_inc),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        ne       = 1'b0;
        pcsrc    = PCSRC_ALU;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        immsel   = 1'b0;
        aluop    = ALUOP_ADD;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        half     = 1'b0;
        b        = 1'b0;
        illegal  = 1'b0;
        buserr   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                if (ready_eff) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    buserr  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW, OP_LH, OP_LB: state_d = S_MEMADR;
                    OP_RTYPE:                   state_d = S_EXEC;
                    OP_BEQ, OP_BNE:             state_d = S_BRANCH;
                    OP_ADDI:                    state_d = S_ADDIEX;
                    OP_ORI:                     state_d = S_ORIEX;
                    OP_J:                       state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                half    = (op == OP_LH);
                b       = (op == OP_LB);
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                half    = (op == OP_LH);
                b       = (op == OP_LB);
                if (ready_eff) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    buserr  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                half     = (op == OP_LH);
                b        = (op == OP_LB);
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready_eff) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    buserr  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_IWB;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                immsel  = 1'b1;
                aluop   = ALUOP_OR;
                state_d = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = PCSRC_ALUOUT;
                ne      = (op == OP_BNE);
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset gates the outputs combinationally so memwrite falls with reset_n.
        if (!reset_n) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            ne       = 1'b0;
            pcsrc    = PCSRC_ALU;
            alusrca  = 1'b0;
            alusrcb  = SRCB_FOUR;
            immsel   = 1'b0;
            aluop    = ALUOP_ADD;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            half     = 1'b0;
            b        = 1'b0;
            illegal  = 1'b0;
            buserr   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl, plus a second instance
// with the memory handshake disabled.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req, iord, irwrite, pcwrite, branch, ne;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immsel;
        logic [1:0] aluop;
        logic       regdst, memtoreg, regwrite, memwrite, half, b, illegal, buserr;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] op;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, mem_ready;
    logic [5:0] op;
    logic       mem_req, iord, irwrite, pcwrite, branch, ne, alusrca, immsel;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic       regdst, memtoreg, regwrite, memwrite, half, b, illegal, buserr;

    logic       reset_n2, mem_ready2;
    logic [5:0] op2;
    logic       mem_req2, iord2, irwrite2, pcwrite2, branch2, ne2, alusrca2, immsel2;
    logic [1:0] pcsrc2, alusrcb2, aluop2;
    logic       regdst2, memtoreg2, regwrite2, memwrite2, half2, b2, illegal2, buserr2;

    multicycle_ctrl #(.MEM_HANDSHAKE(1), .WAIT_MAX(15)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .ne(ne), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsel(immsel), .aluop(aluop), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .memwrite(memwrite),
        .half(half), .b(b), .illegal(illegal), .buserr(buserr)
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(0), .WAIT_MAX(2)) dut_nh (
        .clk(clk), .reset_n(reset_n2), .op(op2), .mem_ready(mem_ready2),
        .mem_req(mem_req2), .iord(iord2), .irwrite(irwrite2), .pcwrite(pcwrite2),
        .branch(branch2), .ne(ne2), .pcsrc(pcsrc2), .alusrca(alusrca2),
        .alusrcb(alusrcb2), .immsel(immsel2), .aluop(aluop2), .regdst(regdst2),
        .memtoreg(memtoreg2), .regwrite(regwrite2), .memwrite(memwrite2),
        .half(half2), .b(b2), .illegal(illegal2), .buserr(buserr2)
    );

    outs_t act, act2;
    assign act  = {mem_req, iord, irwrite, pcwrite, branch, ne, pcsrc, alusrca, alusrcb,
                   immsel, aluop, regdst, memtoreg, regwrite, memwrite, half, b, illegal, buserr};
    assign act2 = {mem_req2, iord2, irwrite2, pcwrite2, branch2, ne2, pcsrc2, alusrca2, alusrcb2,
                   immsel2, aluop2, regdst2, memtoreg2, regwrite2, memwrite2, half2, b2,
                   illegal2, buserr2};

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    outs_t E_RST, E_FW, E_FR, E_FBE, E_DEC, E_ILL, E_MA, E_MRD, E_MBE, E_MWB, E_MWR;
    outs_t E_EXE, E_AWB, E_ADI, E_ORI, E_IWB, E_BEQ, E_BNE, E_JMP;

    function automatic outs_t hb(input outs_t o, input logic h, input logic bb);
        outs_t r = o;
        r.half = h;
        r.b    = bb;
        return r;
    endfunction

    task automatic add(input string n, input logic r, input logic [5:0] o,
                       input logic rdy, input outs_t e);
        vec_t v;
        v.name = n; v.rst_n = r; v.op = o; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input int idx, input outs_t got, input outs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %06h required %06h", n, idx, got, exp);
        end
    endtask

    initial begin
        E_RST = '0; E_RST.alusrcb = 2'b01;
        E_FW  = '0; E_FW.mem_req = 1; E_FW.alusrcb = 2'b01;
        E_FR  = E_FW; E_FR.irwrite = 1; E_FR.pcwrite = 1;
        E_FBE = E_FW; E_FBE.buserr = 1;
        E_DEC = '0; E_DEC.alusrcb = 2'b11;
        E_ILL = E_DEC; E_ILL.illegal = 1;
        E_MA  = '0; E_MA.alusrca = 1; E_MA.alusrcb = 2'b10;
        E_MRD = '0; E_MRD.mem_req = 1; E_MRD.iord = 1;
        E_MBE = E_MRD; E_MBE.buserr = 1;
        E_MWB = '0; E_MWB.regwrite = 1; E_MWB.memtoreg = 1;
        E_MWR = '0; E_MWR.mem_req = 1; E_MWR.iord = 1; E_MWR.memwrite = 1;
        E_EXE = '0; E_EXE.alusrca = 1; E_EXE.aluop = 2'b10;
        E_AWB = '0; E_AWB.regdst = 1; E_AWB.regwrite = 1;
        E_ADI = '0; E_ADI.alusrca = 1; E_ADI.alusrcb = 2'b10;
        E_ORI = E_ADI; E_ORI.immsel = 1; E_ORI.aluop = 2'b11;
        E_IWB = '0; E_IWB.regwrite = 1;
        E_BEQ = '0; E_BEQ.alusrca = 1; E_BEQ.aluop = 2'b01; E_BEQ.branch = 1; E_BEQ.pcsrc = 2'b01;
        E_BNE = E_BEQ; E_BNE.ne = 1;
        E_JMP = '0; E_JMP.pcwrite = 1; E_JMP.pcsrc = 2'b10;

        add("rst", 0, OP_LW, 1, E_RST);
        add("rst", 0, OP_LW, 1, E_RST);
        add("lw_fetch", 1, OP_LW, 1, E_FR);
        add("lw_dec",   1, OP_LW, 1, E_DEC);
        add("lw_madr",  1, OP_LW, 1, E_MA);
        add("lw_mrd",   1, OP_LW, 1, E_MRD);
        add("lw_mwb",   1, OP_LW, 1, E_MWB);
        add("sw_fetch", 1, OP_SW, 1, E_FR);
        add("sw_dec",   1, OP_SW, 1, E_DEC);
        add("sw_madr",  1, OP_SW, 1, E_MA);
        for (int i = 0; i < 3; i++) add("sw_mwr_wait", 1, OP_SW, 0, E_MWR);
        add("sw_mwr_done", 1, OP_SW, 1, E_MWR);
        add("r_fetch", 1, OP_RTYPE, 1, E_FR);
        add("r_dec",   1, OP_RTYPE, 1, E_DEC);
        add("r_exec",  1, OP_RTYPE, 1, E_EXE);
        add("r_aluwb", 1, OP_RTYPE, 1, E_AWB);
        add("beq_fetch", 1, OP_BEQ, 1, E_FR);
        add("beq_dec",   1, OP_BEQ, 1, E_DEC);
        add("beq_br",    1, OP_BEQ, 1, E_BEQ);
        add("bne_fetch", 1, OP_BNE, 1, E_FR);
        add("bne_dec",   1, OP_BNE, 1, E_DEC);
        add("bne_br",    1, OP_BNE, 1, E_BNE);
        add("lb_fetch", 1, OP_LB, 1, E_FR);
        add("lb_dec",   1, OP_LB, 1, E_DEC);
        add("lb_madr",  1, OP_LB, 1, hb(E_MA, 0, 1));
        add("lb_mrd_w", 1, OP_LB, 0, hb(E_MRD, 0, 1));
        add("lb_mrd",   1, OP_LB, 1, hb(E_MRD, 0, 1));
        add("lb_mwb",   1, OP_LB, 1, hb(E_MWB, 0, 1));
        add("lh_fetch", 1, OP_LH, 1, E_FR);
        add("lh_dec",   1, OP_LH, 1, E_DEC);
        add("lh_madr",  1, OP_LH, 1, hb(E_MA, 1, 0));
        add("lh_mrd",   1, OP_LH, 1, hb(E_MRD, 1, 0));
        add("lh_mwb",   1, OP_LH, 1, hb(E_MWB, 1, 0));
        add("addi_fetch", 1, OP_ADDI, 1, E_FR);
        add("addi_dec",   1, OP_ADDI, 1, E_DEC);
        add("addi_ex",    1, OP_ADDI, 1, E_ADI);
        add("addi_wb",    1, OP_ADDI, 1, E_IWB);
        add("ori_fetch", 1, OP_ORI, 1, E_FR);
        add("ori_dec",   1, OP_ORI, 1, E_DEC);
        add("ori_ex",    1, OP_ORI, 1, E_ORI);
        add("ori_wb",    1, OP_ORI, 1, E_IWB);
        add("j_fetch", 1, OP_J, 1, E_FR);
        add("j_dec",   1, OP_J, 1, E_DEC);
        add("j_jump",  1, OP_J, 1, E_JMP);
        add("ill_fetch", 1, 6'b111111, 1, E_FR);
        add("ill_dec",   1, 6'b111111, 1, E_ILL);
        // Fetch stall: 15 waiting cycles, timeout on the 16th, counter restarts.
        for (int i = 0; i < 15; i++) add("fetch_wait", 1, 6'b111111, 0, E_FW);
        add("fetch_buserr", 1, 6'b111111, 0, E_FBE);
        for (int i = 0; i < 15; i++) add("fetch_wait2", 1, OP_LW, 0, E_FW);
        add("fetch_ready_at_max", 1, OP_LW, 1, E_FR);
        add("to_dec",  1, OP_LW, 1, E_DEC);
        add("to_madr", 1, OP_LW, 1, E_MA);
        for (int i = 0; i < 15; i++) add("mrd_wait", 1, OP_LW, 0, E_MRD);
        add("mrd_buserr", 1, OP_LW, 0, E_MBE);
        add("after_mrd_to", 1, OP_SW, 1, E_FR);
        add("rsw_dec",  1, OP_SW, 1, E_DEC);
        add("rsw_madr", 1, OP_SW, 1, E_MA);
        add("rsw_mwr",  1, OP_SW, 0, E_MWR);
        add("rsw_mwr",  1, OP_SW, 0, E_MWR);
        add("rsw_reset", 0, OP_SW, 0, E_RST);
        add("post_rst_fetch", 1, OP_J, 0, E_FW);
        add("post_rst_fetch_r", 1, OP_J, 1, E_FR);
        add("post_rst_dec",  1, OP_J, 1, E_DEC);
        add("post_rst_jump", 1, OP_J, 1, E_JMP);
        add("final_fetch",   1, OP_J, 1, E_FR);

        reset_n2 = 1'b0; mem_ready2 = 1'b0; op2 = OP_LW;
        reset_n = 1'b0; op = OP_LW; mem_ready = 1'b1;

        foreach (vecs[i]) begin
            reset_n   = vecs[i].rst_n;
            op        = vecs[i].op;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            check(vecs[i].name, i, act, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // No-handshake instance: mem_ready tied low, memory states still single-cycle.
        @(negedge clk);
        check("nh_rst", 0, act2, E_RST);
        @(posedge clk);
        #1;
        reset_n2 = 1'b1;
        begin
            outs_t nh_seq[5];
            nh_seq[0] = E_FR; nh_seq[1] = E_DEC; nh_seq[2] = E_MA;
            nh_seq[3] = E_MRD; nh_seq[4] = E_MWB;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("nh_lw", k, act2, nh_seq[k]);
                @(posedge clk);
                #1;
            end
            op2 = OP_SW;
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                n_tests++;
                if (buserr2 !== 1'b0 || illegal2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nh_no_buserr [%0d]: got buserr=%b illegal=%b required 0", k,
                             buserr2, illegal2);
                end
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle MIPS control unit that replaces the single-cycle main decoder with a Moore FSM. It sequences fetch, decode, execute, memory and writeback for RTYPE, LW, SW, BEQ, BNE, ADDI, ORI, J, LH and LB. It adds a parametrised memory request/ready handshake with a wait-state timeout, plus illegal-opcode and bus-error reporting. It sits between the instruction register (op) and the shared multicycle datapath; the ALU decoder remains separate and is driven by aluop.

Parameters:
MEM_HANDSHAKE, 1, 1 = wait for mem_ready in memory states; 0 = mem_ready is ignored and treated as 1.
WAIT_MAX, 15, maximum wait cycles in one memory state before a bus-error abort (must be >= 1).
WAIT_W, $clog2(WAIT_MAX+1), width of the wait counter (derived).

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
op  in  6  opcode from the instruction register (stable from DECODE onward)
mem_ready  in  1  memory has completed the current request
mem_req  out  1  memory access request
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
irwrite  out  1  load the instruction register
pcwrite  out  1  unconditional PC write
branch  out  1  conditional PC write
ne  out  1  branch on not-equal (BNE)
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = constant 4, 10 = immediate, 11 = immediate<<2
immsel  out  1  0 = sign-extend, 1 = zero-extend
aluop  out  2  00 = add, 01 = sub, 10 = funct, 11 = or
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  writeback from memory data
regwrite  out  1  register file write
memwrite  out  1  memory write
half  out  1  halfword load (LH)
b  out  1  byte load (LB)
illegal  out  1  one-cycle pulse: unknown opcode
buserr  out  1  one-cycle pulse: memory timeout

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ORIEX, IWB, BRANCH, JUMP.
- Reset (async, while reset_n = 0): state = FETCH, wait counter = 0. All enables (mem_req, irwrite, pcwrite, branch, regwrite, memwrite) and all pulses are forced to 0. Every other output is 0 except alusrcb = 01.
- Outputs are Moore outputs decoded from state; the only Mealy terms are the ready-gating noted below. Any output not listed for a state is 0.
- FETCH: mem_req = 1, alusrcb = 01, aluop = 00. irwrite and pcwrite are asserted only in the cycle mem_ready = 1, which moves the FSM to DECODE. Otherwise the FSM stays in FETCH.
- DECODE (1 cycle): alusrcb = 11, aluop = 00. Next state by op:
  - LW, SW, LH, LB -> MEMADR
  - RTYPE -> EXEC
  - BEQ, BNE -> BRANCH
  - ADDI -> ADDIEX
  - ORI -> ORIEX
  - J -> JUMP
  - any other op -> illegal = 1 for this cycle, then FETCH
- MEMADR: alusrca = 1, alusrcb = 10. SW goes to MEMWR; all other memory ops go to MEMRD.
- MEMRD: mem_req = 1, iord = 1. Advances to MEMWB on mem_ready.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0, then FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = 1, all held until mem_ready; then FETCH.
- half and b: half = 1 when op = LH, b = 1 when op = LB, in MEMADR, MEMRD and MEMWB.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 10. Then ALUWB: regdst = 1, regwrite = 1, then FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. ORIEX: same but immsel = 1 and aluop = 11. Both go to IWB: regwrite = 1, regdst = 0, then FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, branch = 1, pcsrc = 01, ne = 1 only for BNE; then FETCH. The datapath forms pcen = pcwrite | (branch & (zero ^ ne)).
- JUMP: pcwrite = 1, pcsrc = 10, then FETCH.
- Wait counter:
  - Clears on entry to any memory state (FETCH, MEMRD, MEMWR) and whenever mem_ready = 1.
  - Increments each cycle the FSM is in a memory state with mem_ready = 0.
  - When the count equals WAIT_MAX with mem_ready still 0: buserr = 1 for that cycle, the write/read is dropped (no irwrite, pcwrite, regwrite), and the next state is FETCH with the PC unchanged.
  - mem_ready arriving in the WAIT_MAX cycle wins: normal completion, no buserr.
- MEM_HANDSHAKE = 0: every memory state is a single cycle and buserr is never asserted.
- Reset mid-operation: immediate abort to FETCH. memwrite drops asynchronously with reset_n.

Decomposition:
- mips_ctrl_pkg holds: opcode localparams (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_ADDI 001000, OP_ORI 001101, OP_J 000010, OP_LH 100001, OP_LB 100000), the state enum, and the aluop/pcsrc/alusrcb encodings.
- Sub-module mem_wait_timer (parameter WAIT_MAX; inputs clk, reset_n, clr, inc; output expired) holds the counter.

Test Plan:
- LW, mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH over 5 cycles; regwrite = 1 and memtoreg = 1 only in cycle 5; buserr = 0.
- SW, mem_ready low for 3 cycles in MEMWR -> memwrite and mem_req held for 4 cycles, then FETCH; regwrite never asserted.
- BNE -> BRANCH state shows branch = 1, ne = 1, pcsrc = 01, aluop = 01; repeat with BEQ -> ne = 0.
- LB then LH -> b = 1 (half = 0) for the LB sequence, half = 1 (b = 0) for the LH sequence, across MEMADR through MEMWB.
- op = 111111 -> illegal = 1 for exactly the DECODE cycle, next state FETCH, no enables asserted; ORI -> immsel = 1 and aluop = 11 in ORIEX.
- WAIT_MAX = 15, mem_ready held 0 in FETCH -> buserr pulses in the 16th FETCH cycle, irwrite stays 0; reset_n pulsed low mid-MEMWR -> memwrite = 0 immediately and state = FETCH after release.
